// File: rtl/sram_rd_pkg.sv
// Shared constants and FSM state type for the SRAM stream reader.
// The output buffer depth is fixed at 2. That is the minimum depth that sustains 1 word/cycle
// behind a 1-cycle-latency SRAM.
package sram_rd_pkg;

   localparam int unsigned SRAM_DEPTH = 16;
   localparam int unsigned ADDR_W     = 4;
   localparam int unsigned LEN_W      = 5;
   localparam int unsigned FIFO_DEPTH = 2;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN,
      DONE
   } rd_state_e;

endpackage

// File: rtl/sram_rd_skid_fifo.sv
// 2-entry synchronous FIFO that holds SRAM read data until the stream consumer takes it.
// The caller guarantees there is no push when full and no pop when empty.
module sram_rd_skid_fifo #(
   parameter int unsigned Width = 64
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             pop_i,
   output logic [1:0]       count_o,
   output logic [Width-1:0] head_o
);

   logic [Width-1:0] mem_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       count_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_i) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
      end
   end

   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/sram_w16_stream_reader.sv
// Reads a run of consecutive addresses from the 16-entry input SRAM. The words are streamed out
// on a valid/ready interface, and a credit check keeps buffered + in-flight words within the FIFO.
module sram_w16_stream_reader
   import sram_rd_pkg::*;
#(
   parameter int unsigned sram_bit = 64
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                start_i,
   input  logic [ADDR_W-1:0]   base_addr_i,
   input  logic [LEN_W-1:0]    len_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                sram_cen_o,
   output logic                sram_wen_o,
   output logic [ADDR_W-1:0]   sram_a_o,
   input  logic [sram_bit-1:0] sram_q_i,
   output logic [sram_bit-1:0] out_data_o,
   output logic                out_valid_o,
   input  logic                out_ready_i
);

   rd_state_e         state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  issued_q, issued_d;
   logic [LEN_W-1:0]  popped_q, popped_d;
   logic              inflight_q;
   logic              busy_q, done_q;

   logic [1:0]        fifo_count;
   logic [2:0]        occupancy;
   logic              pop;
   logic              issue;

   assign out_valid_o = (fifo_count != 2'd0);
   assign pop         = out_valid_o & out_ready_i;

   // Credit counts this cycle's pop so that issue can continue back-to-back under a steady drain.
   assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
   assign issue     = (state_q == READ) && (issued_q < len_q) && (occupancy < 3'(FIFO_DEPTH));

   assign sram_cen_o = ~issue;
   assign sram_wen_o = 1'b1;
   assign sram_a_o   = base_q + issued_q[ADDR_W-1:0];

   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      len_d    = len_q;
      issued_d = issued_q;
      popped_d = popped_q;
      if (issue) begin
         issued_d = issued_q + LEN_W'(1);
      end
      if (pop && (popped_q < len_q)) begin
         popped_d = popped_q + LEN_W'(1);
      end
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               base_d   = base_addr_i;
               len_d    = len_i;
               issued_d = '0;
               popped_d = '0;
               state_d  = (len_i == '0) ? DONE : READ;
            end
         end
         READ: begin
            if (issue && (issued_q + LEN_W'(1) == len_q)) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if ((popped_d == len_q) && !inflight_q) begin
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         base_q     <= '0;
         len_q      <= '0;
         issued_q   <= '0;
         popped_q   <= '0;
         inflight_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         len_q      <= len_d;
         issued_q   <= issued_d;
         popped_q   <= popped_d;
         inflight_q <= issue;
         busy_q     <= (state_d != IDLE);
         done_q     <= (state_d == DONE);
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;

   sram_rd_skid_fifo #(
      .Width (sram_bit)
   ) u_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .push_i  (inflight_q),
      .data_i  (sram_q_i),
      .pop_i   (pop),
      .count_o (fifo_count),
      .head_o  (out_data_o)
   );

endmodule

// File: tb/tb_sram_w16_stream_reader.sv
// Directed bench for sram_w16_stream_reader, driven against a behavioural 16x64 SRAM
// whose entries hold mem[i] = i * 0x0101...01.
module tb_sram_w16_stream_reader;

   localparam int unsigned W = 64;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [3:0]    base_addr = '0;
   logic [4:0]    len = '0;
   logic          busy, done, cen, wen;
   logic [3:0]    a;
   logic [W-1:0]  q = '0;
   logic [W-1:0]  out_data;
   logic          out_valid;
   logic          out_ready = 1'b0;

   int tests_run = 0;
   int fails = 0;

   logic [W-1:0] mem [16];
   logic [3:0]   addr_log [$];
   logic [W-1:0] data_log [$];
   int           done_cnt = 0, n_iss = 0, n_pop = 0, occ_err = 0, stall_err = 0;
   logic         prev_stall = 1'b0;
   logic [W-1:0] prev_data = '0;

   always #5 clk = ~clk;

   sram_w16_stream_reader #(
      .sram_bit (W)
   ) dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .start_i     (start),
      .base_addr_i (base_addr),
      .len_i       (len),
      .busy_o      (busy),
      .done_o      (done),
      .sram_cen_o  (cen),
      .sram_wen_o  (wen),
      .sram_a_o    (a),
      .sram_q_i    (q),
      .out_data_o  (out_data),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready)
   );

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 64'h0101010101010101 * 64'(i);
   end

   always @(posedge clk) begin
      if (cen === 1'b0) q <= mem[a];
   end

   // Observer on the inactive edge: logs issued addresses, handshaked beats and protocol slips.
   always @(negedge clk) begin
      if (cen === 1'b0) begin
         addr_log.push_back(a);
         n_iss++;
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         data_log.push_back(out_data);
         n_pop++;
      end
      if (n_iss - n_pop > 2) occ_err++;
      if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data)) stall_err++;
      prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
      prev_data  = out_data;
      if (done === 1'b1) done_cnt++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      addr_log.delete();
      data_log.delete();
      done_cnt = 0; n_iss = 0; n_pop = 0; occ_err = 0; stall_err = 0;
      prev_stall = 1'b0;
   endtask

   task automatic start_run(input logic [3:0] b, input logic [4:0] l);
      step();
      start = 1'b1; base_addr = b; len = l;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin
         step();
         n++;
      end
      tests_run++;
      if (done_cnt == 0) begin
         fails++;
         $display("FAIL %s_done_timeout: done_cnt=%0d required >=1", name, done_cnt);
      end
      repeat (3) step();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) step();
      tests_run++;
      if ({cen, wen, a, out_valid, busy, done} !== {1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL reset_ctrl: cen=%b wen=%b a=%0d valid=%b busy=%b done=%b required 1 1 0 0 0 0",
                  cen, wen, a, out_valid, busy, done);
      end
      tests_run++;
      if (out_data !== '0) begin
         fails++;
         $display("FAIL reset_data: out_data=%h required 0", out_data);
      end
      reset = 1'b0;
      clear_log();
      repeat (5) step();
      tests_run++;
      if (addr_log.size() != 0 || done_cnt != 0) begin
         fails++;
         $display("FAIL reset_idle: reads=%0d done=%0d required 0 0", addr_log.size(), done_cnt);
      end
   endtask

   task automatic test_basic();
      logic [7:0] cen_v, val_v, done_v, busy_v;
      logic [3:0] exp_a [4];
      exp_a[0] = 4'd3; exp_a[1] = 4'd4; exp_a[2] = 4'd5; exp_a[3] = 4'd6;
      clear_log();
      out_ready = 1'b1;
      step();
      start = 1'b1; base_addr = 4'd3; len = 5'd4;
      @(posedge clk);
      #1 start = 1'b0;
      // Index k is the cycle following edge E_k, where E0 is the start-sampling edge.
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         cen_v[k] = cen; val_v[k] = out_valid; done_v[k] = done; busy_v[k] = busy;
      end
      tests_run++;
      if (cen_v !== 8'b1111_0000) begin
         fails++;
         $display("FAIL basic_cen_timing: got %b required 11110000", cen_v);
      end
      tests_run++;
      if (val_v !== 8'b0011_1100) begin
         fails++;
         $display("FAIL basic_valid_timing: got %b required 00111100", val_v);
      end
      tests_run++;
      if (done_v !== 8'b0100_0000 || busy_v !== 8'b0111_1111) begin
         fails++;
         $display("FAIL basic_done_busy: done=%b busy=%b required 01000000 01111111", done_v, busy_v);
      end
      repeat (3) step();
      tests_run++;
      if (addr_log.size() != 4) begin
         fails++;
         $display("FAIL basic_read_count: got %0d required 4", addr_log.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (addr_log[i] !== exp_a[i]) begin
               fails++;
               $display("FAIL basic_addr[%0d]: got %0d required %0d", i, addr_log[i], exp_a[i]);
            end
         end
      end
      tests_run++;
      if (data_log.size() != 4) begin
         fails++;
         $display("FAIL basic_beats: got %0d required 4", data_log.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (data_log[i] !== mem[3 + i]) begin
               fails++;
               $display("FAIL basic_data[%0d]: got %h required %h", i, data_log[i], mem[3 + i]);
            end
         end
      end
      tests_run++;
      if (done_cnt != 1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL basic_end: done_cnt=%0d busy=%b required 1 0", done_cnt, busy);
      end
   endtask

   task automatic test_wrap();
      logic [3:0] exp_a [4];
      exp_a[0] = 4'd14; exp_a[1] = 4'd15; exp_a[2] = 4'd0; exp_a[3] = 4'd1;
      clear_log();
      out_ready = 1'b1;
      start_run(4'd14, 5'd4);
      wait_done(40, "wrap");
      tests_run++;
      if (addr_log.size() != 4 || data_log.size() != 4) begin
         fails++;
         $display("FAIL wrap_count: reads=%0d beats=%0d required 4 4", addr_log.size(), data_log.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (addr_log[i] !== exp_a[i] || data_log[i] !== mem[exp_a[i]]) begin
               fails++;
               $display("FAIL wrap[%0d]: addr=%0d data=%h required %0d %h",
                        i, addr_log[i], data_log[i], exp_a[i], mem[exp_a[i]]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [39:0] pat;
      pat = 40'b1101_0110_1000_0000_0011_0101_1001_1011_0010_1110;
      clear_log();
      out_ready = 1'b0;
      start_run(4'd0, 5'd8);
      for (int i = 0; i < 300 && done_cnt == 0; i++) begin
         out_ready = (i < 40) ? pat[i] : 1'b1;
         step();
      end
      out_ready = 1'b1;
      wait_done(40, "bp");
      tests_run++;
      if (data_log.size() != 8 || addr_log.size() != 8) begin
         fails++;
         $display("FAIL bp_count: beats=%0d reads=%0d required 8 8", data_log.size(), addr_log.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (data_log[i] !== mem[i]) begin
               fails++;
               $display("FAIL bp_data[%0d]: got %h required %h", i, data_log[i], mem[i]);
            end
         end
      end
      tests_run++;
      if (occ_err != 0) begin
         fails++;
         $display("FAIL bp_outstanding: violations=%0d required 0", occ_err);
      end
      tests_run++;
      if (stall_err != 0) begin
         fails++;
         $display("FAIL bp_stable: violations=%0d required 0", stall_err);
      end
      tests_run++;
      if (done_cnt != 1) begin
         fails++;
         $display("FAIL bp_done: got %0d required 1", done_cnt);
      end
   endtask

   task automatic test_len_zero();
      clear_log();
      out_ready = 1'b1;
      step();
      start = 1'b1; base_addr = 4'd5; len = 5'd0;
      @(posedge clk);
      // A second request while busy must be ignored.
      #1 len = 5'd3;
      @(negedge clk);
      tests_run++;
      if (done !== 1'b1 || busy !== 1'b1) begin
         fails++;
         $display("FAIL len0_pulse: done=%b busy=%b required 1 1", done, busy);
      end
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      tests_run++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL len0_end: done=%b busy=%b required 0 0", done, busy);
      end
      repeat (6) step();
      tests_run++;
      if (addr_log.size() != 0 || done_cnt != 1) begin
         fails++;
         $display("FAIL len0_ignored: reads=%0d done_cnt=%0d required 0 1", addr_log.size(), done_cnt);
      end
   endtask

   task automatic test_reset_midrun();
      int n = 0;
      clear_log();
      out_ready = 1'b1;
      start_run(4'd0, 5'd16);
      while (data_log.size() < 5 && n < 50) begin
         step();
         n++;
      end
      reset = 1'b1;
      repeat (2) step();
      reset = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({busy, out_valid, cen, done} !== 4'b0010) begin
         fails++;
         $display("FAIL midrun_idle: busy=%b valid=%b cen=%b done=%b required 0 0 1 0",
                  busy, out_valid, cen, done);
      end
      tests_run++;
      if (done_cnt != 0) begin
         fails++;
         $display("FAIL midrun_no_done: got %0d required 0", done_cnt);
      end
      clear_log();
      start_run(4'd8, 5'd2);
      wait_done(40, "midrun_restart");
      tests_run++;
      if (data_log.size() != 2) begin
         fails++;
         $display("FAIL restart_count: got %0d required 2", data_log.size());
      end else if (data_log[0] !== mem[8] || data_log[1] !== mem[9]) begin
         fails++;
         $display("FAIL restart_data: got %h %h required %h %h",
                  data_log[0], data_log[1], mem[8], mem[9]);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_len_zero();
      test_reset_midrun();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
